// File: rtl/ahb_pixel_fifo_slave.sv
// AHB-lite fabric slave that packs an 8-bit pixel stream into 32-bit words,
// buffers them in a FIFO and exposes DATA/STATUS/CTRL/IRQ_THRESH registers.
// Zero wait states; read data comes straight from the FIFO head (first word
// falls through), and a DATA read pops at the end of its data phase.
module ahb_pixel_fifo_slave #(
  parameter int FIFO_AW    = 9,
  parameter int THRESH_RST = 256
) (
  input  logic        FAB_CLK,
  input  logic        M2F_RESET_N,
  input  logic [19:0] MSSHADDR,
  input  logic [1:0]  MSSHTRANS,
  input  logic        MSSHWRITE,
  input  logic [1:0]  MSSHSIZE,
  input  logic [31:0] MSSHWDATA,
  output logic [31:0] MSSHRDATA,
  output logic        MSSHREADY,
  output logic        MSSHRESP,
  output logic        FABINT,
  input  logic        px_valid,
  input  logic        px_sof,
  input  logic [7:0]  px_data
);

  localparam logic [FIFO_AW:0] DEPTH       = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] THRESH_INIT = THRESH_RST[FIFO_AW:0];

  // Captured address phase
  logic             dp_valid, dp_write;
  logic [1:0]       dp_addr;
  // Control / status
  logic             cap_en, irq_en, ovf, unf;
  logic [FIFO_AW:0] thresh;
  // FIFO
  logic [31:0]        mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   level, level_n;
  // Packer
  logic [1:0]  lane_cnt, lane_n;
  logic [23:0] pack_buf, buf_n;
  logic        push;
  logic [31:0] push_word;

  logic wr_status, wr_ctrl, wr_thresh, rd_data;
  logic empty, full, pop, push_ok, flush;
  logic irq_en_n;
  logic [FIFO_AW:0] thresh_n;

  // Upper address bits, size and unused write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{MSSHSIZE, MSSHADDR[19:4], MSSHADDR[1:0], MSSHTRANS[0], MSSHWDATA};

  assign MSSHREADY = 1'b1;
  assign MSSHRESP  = 1'b0;

  // Register the address phase; with HREADY tied high every cycle is a new address phase.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_valid <= MSSHTRANS[1];
      dp_write <= MSSHWRITE;
      dp_addr  <= MSSHADDR[3:2];
    end
  end

  assign wr_status = dp_valid &  dp_write & (dp_addr == 2'd1);
  assign wr_ctrl   = dp_valid &  dp_write & (dp_addr == 2'd2);
  assign wr_thresh = dp_valid &  dp_write & (dp_addr == 2'd3);
  assign rd_data   = dp_valid & ~dp_write & (dp_addr == 2'd0);

  assign empty    = (level == '0);
  assign full     = (level == DEPTH);
  assign pop      = rd_data & ~empty;
  assign flush    = wr_ctrl & MSSHWDATA[2];
  assign push_ok  = push & (~full | pop);
  assign irq_en_n = wr_ctrl ? MSSHWDATA[1] : irq_en;
  assign thresh_n = wr_thresh ? MSSHWDATA[FIFO_AW:0] : thresh;

  // Packer next state: collect bytes into lanes 0..2, push on the 4th byte.
  always_comb begin
    lane_n    = lane_cnt;
    buf_n     = pack_buf;
    push      = 1'b0;
    push_word = {px_data, pack_buf};
    if (!cap_en) begin
      lane_n = 2'd0;
    end else if (px_valid) begin
      if (px_sof) begin
        buf_n  = {16'h0000, px_data};
        lane_n = 2'd1;
      end else begin
        case (lane_cnt)
          2'd0:    buf_n[7:0]   = px_data;
          2'd1:    buf_n[15:8]  = px_data;
          2'd2:    buf_n[23:16] = px_data;
          default: push         = 1'b1;
        endcase
        lane_n = lane_cnt + 2'd1;
      end
    end
  end

  // Post-update fill level; flush overrides any push or pop.
  always_comb begin
    level_n = level;
    if (flush)                 level_n = '0;
    else if (push_ok && !pop)  level_n = level + 1'b1;
    else if (pop && !push_ok)  level_n = level - 1'b1;
  end

  // FIFO storage has no reset; only the pointers define what is valid.
  always_ff @(posedge FAB_CLK) begin
    if (push_ok && !flush) mem[wptr] <= push_word;
  end

  // Pointers, packer, sticky flags, control registers and the interrupt.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      lane_cnt <= 2'd0;
      pack_buf <= 24'h0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      cap_en   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= THRESH_INIT;
      FABINT   <= 1'b0;
    end else begin
      level  <= level_n;
      irq_en <= irq_en_n;
      thresh <= thresh_n;
      if (wr_ctrl) cap_en <= MSSHWDATA[0];
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        lane_cnt <= 2'd0;
        pack_buf <= 24'h0;
        ovf      <= 1'b0;
        unf      <= 1'b0;
      end else begin
        lane_cnt <= lane_n;
        pack_buf <= buf_n;
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
        // A new event in the same cycle as a W1C keeps the flag set.
        if (push && !push_ok)                   ovf <= 1'b1;
        else if (wr_status && MSSHWDATA[18])    ovf <= 1'b0;
        if (rd_data && empty)                   unf <= 1'b1;
        else if (wr_status && MSSHWDATA[19])    unf <= 1'b0;
      end
      FABINT <= irq_en_n && (thresh_n != '0) && (level_n >= thresh_n);
    end
  end

  // Read mux from the captured address; DATA reads 0 when the FIFO is empty.
  always_comb begin
    MSSHRDATA = 32'h0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        2'd0:    MSSHRDATA = empty ? 32'h0 : mem[rptr];
        2'd1:    MSSHRDATA = {12'h000, unf, ovf, full, empty, 16'(level)};
        2'd2:    MSSHRDATA = {30'h0, irq_en, cap_en};
        default: MSSHRDATA = 32'(thresh);
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_pixel_fifo_slave.sv
// Bench for ahb_pixel_fifo_slave with a 4-word FIFO: a register/pixel
// vector table followed by hand-written multi-cycle sequences.
module tb_ahb_pixel_fifo_slave;

  logic        FAB_CLK = 1'b0;
  logic        M2F_RESET_N;
  logic [19:0] MSSHADDR;
  logic [1:0]  MSSHTRANS;
  logic        MSSHWRITE;
  logic [1:0]  MSSHSIZE;
  logic [31:0] MSSHWDATA;
  logic [31:0] MSSHRDATA;
  logic        MSSHREADY;
  logic        MSSHRESP;
  logic        FABINT;
  logic        px_valid;
  logic        px_sof;
  logic [7:0]  px_data;

  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_THRESH = 2'd3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  typedef enum int {OP_WR, OP_RD, OP_PX} op_t;
  typedef struct {
    op_t         op;
    logic [1:0]  rsel;
    logic [31:0] data;
    logic        sof;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  ahb_pixel_fifo_slave #(.FIFO_AW(2), .THRESH_RST(4)) dut (
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .MSSHADDR(MSSHADDR),
    .MSSHTRANS(MSSHTRANS), .MSSHWRITE(MSSHWRITE), .MSSHSIZE(MSSHSIZE),
    .MSSHWDATA(MSSHWDATA), .MSSHRDATA(MSSHRDATA), .MSSHREADY(MSSHREADY),
    .MSSHRESP(MSSHRESP), .FABINT(FABINT), .px_valid(px_valid),
    .px_sof(px_sof), .px_data(px_data)
  );

  // Clock
  always #5 FAB_CLK = ~FAB_CLK;

  // ---- scoreboard helpers ----
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic void add_wr(input logic [1:0] r, input logic [31:0] d);
    vec_t v;
    v.op = OP_WR; v.rsel = r; v.data = d; v.sof = 1'b0; v.exp = '0; v.name = "wr";
    vecs.push_back(v);
  endfunction

  function automatic void add_rd(input logic [1:0] r, input logic [31:0] e, input string n);
    vec_t v;
    v.op = OP_RD; v.rsel = r; v.data = '0; v.sof = 1'b0; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic void add_px(input logic [7:0] b, input logic s);
    vec_t v;
    v.op = OP_PX; v.rsel = '0; v.data = {24'h0, b}; v.sof = s; v.exp = '0; v.name = "px";
    vecs.push_back(v);
  endfunction

  // ---- driver tasks (all start and end 1 time unit after a rising edge) ----
  function automatic logic [19:0] reg_addr(input logic [1:0] r);
    logic [15:0] hi;
    hi = 16'($urandom_range(0, 65535));
    return {hi, r, 2'b00};
  endfunction

  task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(r); MSSHWRITE = 1'b1;
    @(posedge FAB_CLK); #1;
    MSSHTRANS = 2'b00; MSSHWRITE = 1'b0; MSSHWDATA = d;
    @(posedge FAB_CLK); #1;
  endtask

  task automatic ahb_read(input logic [1:0] r, output logic [31:0] d);
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(r); MSSHWRITE = 1'b0;
    @(posedge FAB_CLK); #1;
    MSSHTRANS = 2'b00;
    d = MSSHRDATA;
    @(posedge FAB_CLK); #1;
  endtask

  task automatic drive_px(input logic [7:0] b, input logic s);
    px_valid = 1'b1; px_sof = s; px_data = b;
    @(posedge FAB_CLK); #1;
    px_valid = 1'b0; px_sof = 1'b0;
  endtask

  // Back-to-back DATA reads compared against the expected queue.
  task automatic data_burst(input int n);
    logic [31:0] e;
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(R_DATA); MSSHWRITE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge FAB_CLK); #1;
      if (i == n - 1) MSSHTRANS = 2'b00;
      if (exp_q.size() == 0) e = 32'hDEAD_BEEF;
      else e = exp_q.pop_front();
      check("burst_data", MSSHRDATA, e);
    end
    @(posedge FAB_CLK); #1;
  endtask

  task automatic read_check(input logic [1:0] r, input logic [31:0] e, input string n);
    logic [31:0] d;
    ahb_read(r, d);
    check(n, d, e);
  endtask

  initial begin
    M2F_RESET_N = 1'b0;
    MSSHADDR = '0; MSSHTRANS = '0; MSSHWRITE = 1'b0; MSSHSIZE = 2'b10; MSSHWDATA = '0;
    px_valid = 1'b0; px_sof = 1'b0; px_data = '0;

    // ---- vector table ----
    add_rd(R_STATUS, 32'h0001_0000, "reset_status");
    add_rd(R_THRESH, 32'h0000_0004, "reset_thresh");
    add_rd(R_CTRL,   32'h0000_0000, "reset_ctrl");
    add_wr(R_CTRL, 32'h1);
    for (int i = 1; i <= 8; i++) add_px(8'(i), 1'b0);
    add_rd(R_STATUS, 32'h0000_0002, "pack_level2");
    add_rd(R_DATA,   32'h0403_0201, "pack_word0");
    add_rd(R_DATA,   32'h0807_0605, "pack_word1");
    add_rd(R_STATUS, 32'h0001_0000, "pack_drained");
    add_rd(R_DATA,   32'h0000_0000, "unf_data");
    add_rd(R_STATUS, 32'h0009_0000, "unf_status");
    add_wr(R_STATUS, 32'h000C_0000);
    add_rd(R_STATUS, 32'h0001_0000, "w1c_status");
    add_wr(R_THRESH, 32'hFFFF_FFFF);
    add_rd(R_THRESH, 32'h0000_0007, "thresh_mask");
    add_wr(R_THRESH, 32'h4);
    add_wr(R_DATA, 32'h1234_5678);
    add_rd(R_STATUS, 32'h0001_0000, "data_wr_ignored");
    add_rd(R_CTRL,   32'h0000_0001, "ctrl_capen");
    add_px(8'h11, 1'b0); add_px(8'h22, 1'b0); add_px(8'h33, 1'b0);
    add_px(8'hA0, 1'b1); add_px(8'hA1, 1'b0); add_px(8'hA2, 1'b0); add_px(8'hA3, 1'b0);
    add_rd(R_STATUS, 32'h0000_0001, "sof_level1");
    add_rd(R_DATA,   32'hA3A2_A1A0, "sof_word");
    add_px(8'h55, 1'b0); add_px(8'h66, 1'b0);
    add_wr(R_CTRL, 32'h0);
    add_px(8'h77, 1'b0);
    add_wr(R_CTRL, 32'h1);
    for (int i = 1; i <= 4; i++) add_px(8'(8'hC0 + i), 1'b0);
    add_rd(R_STATUS, 32'h0000_0001, "capen_clear_level");
    add_rd(R_DATA,   32'hC4C3_C2C1, "capen_clear_word");

    // Reset release away from the clock edge
    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK); M2F_RESET_N = 1'b1;
    @(posedge FAB_CLK); #1;
    check("reset_fabint", {31'h0, FABINT}, 32'h0);
    check("hready", {30'h0, MSSHRESP, MSSHREADY}, 32'h1);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR: ahb_write(vecs[i].rsel, vecs[i].data);
        OP_RD: begin ahb_read(vecs[i].rsel, rd); check(vecs[i].name, rd, vecs[i].exp); end
        default: drive_px(vecs[i].data[7:0], vecs[i].sof);
      endcase
    end

    // ---- overflow: 24 pixels into a 4-word FIFO ----
    for (int i = 0; i < 24; i++) drive_px(8'(i), 1'b0);
    read_check(R_STATUS, 32'h0006_0004, "ovf_status");
    exp_q.push_back(32'h0302_0100); exp_q.push_back(32'h0706_0504);
    exp_q.push_back(32'h0B0A_0908); exp_q.push_back(32'h0F0E_0D0C);
    data_burst(4);
    read_check(R_STATUS, 32'h0005_0000, "ovf_drained");
    ahb_write(R_STATUS, 32'h0004_0000);
    read_check(R_STATUS, 32'h0001_0000, "ovf_cleared");

    // ---- push accepted while full because a pop lands in the same cycle ----
    for (int i = 0; i < 19; i++) drive_px(8'(8'h20 + i), 1'b0);
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(R_DATA); MSSHWRITE = 1'b0;
    @(posedge FAB_CLK); #1;
    MSSHTRANS = 2'b00;
    px_valid = 1'b1; px_data = 8'h33;
    check("full_pop_data", MSSHRDATA, 32'h2322_2120);
    @(posedge FAB_CLK); #1;
    px_valid = 1'b0;
    read_check(R_STATUS, 32'h0002_0004, "full_pop_push_status");
    exp_q.push_back(32'h2726_2524); exp_q.push_back(32'h2B2A_2928);
    exp_q.push_back(32'h2F2E_2D2C); exp_q.push_back(32'h3332_3130);
    data_burst(4);
    read_check(R_STATUS, 32'h0001_0000, "full_pop_drained");

    // ---- interrupt threshold timing ----
    ahb_write(R_THRESH, 32'h2);
    ahb_write(R_CTRL, 32'h3);
    for (int i = 0; i < 8; i++) begin
      drive_px(8'(8'h40 + i), 1'b0);
      check($sformatf("irq_px%0d", i), {31'h0, FABINT}, (i == 7) ? 32'h1 : 32'h0);
    end
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(R_DATA); MSSHWRITE = 1'b0;
    @(posedge FAB_CLK); #1;
    MSSHTRANS = 2'b00;
    check("irq_pop_data", MSSHRDATA, 32'h4342_4140);
    check("irq_before_pop", {31'h0, FABINT}, 32'h1);
    @(posedge FAB_CLK); #1;
    check("irq_after_pop", {31'h0, FABINT}, 32'h0);
    for (int i = 0; i < 4; i++) drive_px(8'(8'h48 + i), 1'b0);
    check("irq_rearm", {31'h0, FABINT}, 32'h1);
    ahb_write(R_CTRL, 32'h1);
    check("irq_disabled", {31'h0, FABINT}, 32'h0);
    ahb_write(R_CTRL, 32'h5);
    read_check(R_STATUS, 32'h0001_0000, "flush_status");

    // ---- flush while a word completes in the same cycle ----
    drive_px(8'h60, 1'b0); drive_px(8'h61, 1'b0);
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(R_CTRL); MSSHWRITE = 1'b1;
    px_valid = 1'b1; px_data = 8'h62;
    @(posedge FAB_CLK); #1;
    MSSHTRANS = 2'b00; MSSHWRITE = 1'b0; MSSHWDATA = 32'h7; px_data = 8'h63;
    @(posedge FAB_CLK); #1;
    px_valid = 1'b0;
    read_check(R_STATUS, 32'h0001_0000, "flush_push_status");
    read_check(R_CTRL,   32'h0000_0003, "flush_bit_reads0");
    // flush with a partial word: packer must restart at lane 0
    drive_px(8'h70, 1'b0);
    ahb_write(R_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) drive_px(8'(8'hD0 + i), 1'b0);
    read_check(R_DATA,   32'hD3D2_D1D0, "flush_partial_word");
    read_check(R_STATUS, 32'h0001_0000, "flush_partial_empty");

    // ---- asynchronous reset mid-capture with a transfer in flight ----
    ahb_write(R_THRESH, 32'h1);
    ahb_write(R_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) drive_px(8'(8'h80 + i), 1'b0);
    check("pre_reset_fabint", {31'h0, FABINT}, 32'h1);
    px_valid = 1'b1; px_data = 8'h90;
    MSSHTRANS = 2'b10; MSSHADDR = reg_addr(R_STATUS); MSSHWRITE = 1'b0;
    @(posedge FAB_CLK); #2;
    M2F_RESET_N = 1'b0;
    #1;
    check("async_fabint", {31'h0, FABINT}, 32'h0);
    check("async_rdata", MSSHRDATA, 32'h0);
    check("async_hready", {31'h0, MSSHREADY}, 32'h1);
    MSSHTRANS = 2'b00; px_valid = 1'b0;
    @(negedge FAB_CLK); M2F_RESET_N = 1'b1;
    @(posedge FAB_CLK); #1;
    read_check(R_STATUS, 32'h0001_0000, "post_reset_status");
    read_check(R_THRESH, 32'h0000_0004, "post_reset_thresh");
    read_check(R_CTRL,   32'h0000_0000, "post_reset_ctrl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
